// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: widths, NOP encoding, opcodes and the fetch entry layout.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifu_checker.sv
// Runtime invariants of the fetch unit: no overflowing push, drop count bounded by in-flight count.
module ifu_checker #(
   parameter int CW = 2
) (
   input logic          clk,
   input logic          rst,
   input logic          push,
   input logic          pop,
   input logic          full,
   input logic [CW-1:0] outstanding,
   input logic [CW-1:0] drop_cnt
);

   always @(posedge clk) begin
      if (!rst) begin
         assert (!(push && full && !pop));
         assert (drop_cnt <= outstanding);
      end
   end

endmodule

// File: rtl/ifu_sync_fifo.sv
// Small synchronous FIFO with flush; head is read straight from the register array.
module ifu_sync_fifo #(
   parameter int              DEPTH     = 2,
   parameter int              WIDTH     = 64,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  logic [WIDTH-1:0]        wdata,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic [WIDTH-1:0]        head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push_en;
   logic             w_pop_en;

   assign full      = (r_count == CW'(DEPTH));
   assign empty     = (r_count == {CW{1'b0}});
   assign w_pop_en  = pop && !empty;
   // a full buffer may still accept a word when the head leaves in the same cycle
   assign w_push_en = push && (!full || w_pop_en);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr <= {AW{1'b0}};
         r_wr_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= RESET_VAL;
         end
      end else if (flush) begin
         r_rd_ptr <= {AW{1'b0}};
         r_wr_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         if (w_push_en) begin
            r_mem[r_wr_ptr] <= wdata;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop_en) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push_en) - CW'(w_pop_en);
      end
   end

   assign count = r_count;
   assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch: sequential PC generation, credit-limited imem requests, in-order buffer, redirect flush.
// Optional misaligned-redirect trap enabled by defining IFU_MISALIGN_TRAP_EN.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr_out,
   output logic [XLEN-1:0] instr_pc
`ifdef IFU_MISALIGN_TRAP_EN
   ,
   output logic            fetch_misalign,
   output logic [XLEN-1:0] fetch_misalign_pc
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_rsp_pc;
   logic [CW-1:0]   r_outstanding;
   logic [CW-1:0]   r_drop_cnt;

   logic [CW-1:0]   w_count;
   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_req_fire;
   logic            w_credit_ok;
   logic            w_trap_block;
   logic [CW-1:0]   w_out_next;
   fetch_entry_t    w_wentry;
   fetch_entry_t    w_head;

   // in-flight requests plus buffered words never exceed the buffer depth
   assign w_credit_ok    = ({1'b0, r_outstanding} + {1'b0, w_count}) < (CW+1)'(DEPTH);
   assign imem_req_valid = !rst && !redirect_valid && !w_trap_block && w_credit_ok;
   assign imem_req_addr  = r_fetch_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;
   assign w_out_next     = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);

   assign w_push   = imem_rsp_valid && !redirect_valid && (r_drop_cnt == {CW{1'b0}});
   assign w_pop    = instr_valid && instr_ready;
   assign w_wentry = '{instr: imem_rsp_data, pc: r_rsp_pc};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc    <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_outstanding <= {CW{1'b0}};
         r_drop_cnt    <= {CW{1'b0}};
      end else if (redirect_valid) begin
         // everything still in flight after this cycle belongs to the wrong path
         r_fetch_pc    <= align_pc(redirect_pc);
         r_rsp_pc      <= align_pc(redirect_pc);
         r_outstanding <= w_out_next;
         r_drop_cnt    <= w_out_next;
      end else begin
         r_outstanding <= w_out_next;
         if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         if (imem_rsp_valid) begin
            if (r_drop_cnt != {CW{1'b0}}) begin
               r_drop_cnt <= r_drop_cnt - CW'(1);
            end else begin
               r_rsp_pc <= r_rsp_pc + 32'd4;
            end
         end
      end
   end

`ifdef IFU_MISALIGN_TRAP_EN
   logic            r_misalign;
   logic [XLEN-1:0] r_misalign_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_misalign    <= 1'b0;
         r_misalign_pc <= {XLEN{1'b0}};
      end else if (redirect_valid) begin
         r_misalign <= (redirect_pc[1:0] != 2'b00);
         if (redirect_pc[1:0] != 2'b00) begin
            r_misalign_pc <= redirect_pc;
         end
      end
   end

   assign fetch_misalign    = r_misalign;
   assign fetch_misalign_pc = r_misalign_pc;
   assign w_trap_block      = r_misalign;
`else
   assign w_trap_block = 1'b0;
`endif

   ifu_sync_fifo #(
      .DEPTH     (DEPTH),
      .WIDTH     ($bits(fetch_entry_t)),
      .RESET_VAL ({NOP_INSTR, RESET_PC})
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .flush (redirect_valid),
      .wdata (w_wentry),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count),
      .head  (w_head)
   );

   assign instr_valid = !w_empty;
   assign instr_out   = w_head.instr;
   assign instr_pc    = w_head.pc;

   ifu_checker #(.CW(CW)) u_chk (
      .clk         (clk),
      .rst         (rst),
      .push        (w_push),
      .pop         (w_pop),
      .full        (w_full),
      .outstanding (r_outstanding),
      .drop_cnt    (r_drop_cnt)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit with a variable-latency memory model.
module tb_instr_fetch_unit;
   import riscv_pkg::*;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
`ifdef IFU_MISALIGN_TRAP_EN
   logic        fetch_misalign;
   logic [31:0] fetch_misalign_pc;
`endif

   instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_out      (instr_out),
      .instr_pc       (instr_pc)
`ifdef IFU_MISALIGN_TRAP_EN
      ,
      .fetch_misalign    (fetch_misalign),
      .fetch_misalign_pc (fetch_misalign_pc)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
   typedef struct { logic [31:0] addr; logic [31:0] exp_pc; int due; } mreq_t;

   exp_t        sb[$];
   mreq_t       memq[$];
   int          checks = 0;
   int          failures = 0;
   int          cycle = 0;
   int          last_due = 0;
   int          inflight = 0;
   int          dropn = 0;
   int          delivered = 0;
   bit          popped = 1'b0;
   bit          rst_prev = 1'b0;
   bit          mis_m = 1'b0;
   logic [31:0] mis_pc_m = 32'h0;
   logic [31:0] exp_fetch = RESET_PC;

   int          lat_min = 1, lat_max = 1, rdy_pct = 100, mrdy_pct = 100, redir_pct = 0;
   bit          hold_ready0 = 1'b0;
   bit          force_redir = 1'b0;
   logic [31:0] force_pc = 32'h0;

   // contents of instruction memory: distinct word per address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cycle, act, exp);
      end
   endtask

   // monitor: compares every delivered instruction against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            check("instr_valid", 32'(instr_valid), 32'(sb.size() != 0));
            if (instr_valid && instr_ready && sb.size() != 0) begin
               e = sb.pop_front();
               check("instr_pc", instr_pc, e.pc);
               check("instr_out", instr_out, e.data);
               delivered++;
               popped = 1'b1;
            end
         end
      end
   end

   task automatic step(input bit r);
      logic [31:0] rsp_exp_pc;
      bit          rsp;
      bit          exp_rv;
      int          lat;
      mreq_t       m;
      @(negedge clk);
      rst = r;
      if (r) begin
         instr_ready    = 1'b0;
         redirect_valid = 1'b0;
         redirect_pc    = 32'h0;
      end else begin
         instr_ready = !hold_ready0 && ($urandom_range(0, 99) < rdy_pct);
         if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
         end else if ($urandom_range(0, 99) < redir_pct) begin
            redirect_valid = 1'b1;
            redirect_pc    = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))};
         end else begin
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
         end
      end
      imem_req_ready = ($urandom_range(0, 99) < mrdy_pct);
      if (memq.size() != 0 && memq[0].due <= cycle) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(memq[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      #3;
      if (r) begin
         check("req_valid_in_rst", 32'(imem_req_valid), 32'd0);
         if (rst_prev) begin
            check("rst_instr_valid", 32'(instr_valid), 32'd0);
            check("rst_instr_out", instr_out, NOP_INSTR);
            check("rst_instr_pc", instr_pc, RESET_PC);
         end
         sb.delete();
         memq.delete();
         inflight  = 0;
         dropn     = 0;
         last_due  = 0;
         mis_m     = 1'b0;
         exp_fetch = RESET_PC;
      end else begin
`ifdef IFU_MISALIGN_TRAP_EN
         check("fetch_misalign", 32'(fetch_misalign), 32'(mis_m));
         if (mis_m) check("fetch_misalign_pc", fetch_misalign_pc, mis_pc_m);
`endif
         exp_rv = !redirect_valid && !mis_m && (inflight + sb.size() + int'(popped) < DEPTH);
         check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
         if (imem_req_valid) check("req_addr", imem_req_addr, exp_fetch);
         rsp = imem_rsp_valid;
         rsp_exp_pc = 32'h0;
         if (rsp) begin
            m = memq.pop_front();
            rsp_exp_pc = m.exp_pc;
            inflight--;
         end
         if (redirect_valid) begin
            sb.delete();
            exp_fetch = {redirect_pc[31:2], 2'b00};
            dropn     = inflight;
`ifdef IFU_MISALIGN_TRAP_EN
            mis_m = (redirect_pc[1:0] != 2'b00);
            if (mis_m) mis_pc_m = redirect_pc;
`endif
         end else begin
            if (rsp) begin
               if (dropn > 0) dropn--;
               else sb.push_back('{pc: rsp_exp_pc, data: mem_word(rsp_exp_pc)});
            end
            if (imem_req_valid && imem_req_ready) begin
               lat = $urandom_range(lat_min, lat_max);
               m.addr   = imem_req_addr;
               m.exp_pc = exp_fetch;
               m.due    = (cycle + lat > last_due + 1) ? cycle + lat : last_due + 1;
               last_due = m.due;
               memq.push_back(m);
               inflight++;
               exp_fetch = exp_fetch + 32'd4;
            end
         end
      end
      popped   = 1'b0;
      rst_prev = r;
      cycle++;
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      force_redir = 1'b1;
      force_pc    = pc;
      step(1'b0);
      force_redir = 1'b0;
   endtask

   initial begin
      rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
      repeat (3) step(1'b1);

      // streaming with a 1-cycle memory
      repeat (30) step(1'b0);

      // decode stalls: credit limit must throttle requests
      hold_ready0 = 1'b1;
      repeat (10) step(1'b0);
      hold_ready0 = 1'b0;
      repeat (10) step(1'b0);

      // redirect with responses, pops and requests all active
      repeat (5) step(1'b0);
      redirect_to(32'h0000_0100);
      repeat (10) step(1'b0);

      // 3-cycle memory, redirect while requests are in flight
      lat_min = 3; lat_max = 3;
      repeat (10) step(1'b0);
      redirect_to(32'h0000_0100);
      repeat (15) step(1'b0);

      // back-to-back redirects, then PC wrap-around
      redirect_to(32'h0000_0200);
      redirect_to(32'h0000_0300);
      repeat (12) step(1'b0);
      lat_min = 1; lat_max = 1;
      redirect_to(32'hFFFF_FFF8);
      repeat (10) step(1'b0);

      // misaligned target
      redirect_to(32'h0000_0102);
      repeat (10) step(1'b0);
      redirect_to(32'h0000_0040);
      repeat (5) step(1'b0);

      // random traffic
      lat_min = 1; lat_max = 5; rdy_pct = 70; mrdy_pct = 70; redir_pct = 3;
      repeat (3000) step(1'b0);

      // reset with a full buffer and requests in flight
      redir_pct = 0; rdy_pct = 100; mrdy_pct = 100; lat_min = 3; lat_max = 3;
      redirect_to(32'h0000_0080);
      hold_ready0 = 1'b1;
      repeat (6) step(1'b0);
      hold_ready0 = 1'b0;
      repeat (2) step(1'b1);
      lat_min = 1; lat_max = 1;
      repeat (20) step(1'b0);

      check("delivered_enough", 32'(delivered > 200), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
